// File: rtl/sensor_sdk_sram_cell_arbiter_pkg.sv
// Shared types for the two-port SRAM cell arbiter: FSM encoding and byte-lane width.
`ifndef NUM_BYTE
`define NUM_BYTE(w) ((w) / 8)
`endif

package sensor_sdk_sram_cell_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   function automatic int num_byte(input int width);
      return `NUM_BYTE(width);
   endfunction

endpackage

// File: rtl/sensor_sdk_sram_cell_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the preferred one.
module sensor_sdk_rr_pick2 (
   input  logic [1:0] req,
   input  logic       rr,
   output logic       any,
   output logic       win
);

   assign any = |req;
   assign win = (&req) ? rr : req[1];

endmodule

// File: rtl/sensor_sdk_sram_cell_arbiter.sv
// Shares one synchronous-read SRAM cell between two requesters with round-robin
// ownership, bounded burst hold and registered read-data routing.
module sensor_sdk_sram_cell_arbiter
   import sensor_sdk_sram_cell_arbiter_pkg::*;
#(
   parameter  int BW_INDEX   = 15,
   parameter  int CELL_WIDTH = 32,
   parameter  int MAX_HOLD   = 16,
   localparam int BW_WEN     = num_byte(CELL_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sxreq0,
   input  logic                  sxlast0,
   input  logic                  sxwen0,
   input  logic [BW_INDEX-1:0]   sxindex0,
   input  logic [BW_WEN-1:0]     sxwstrb0,
   input  logic [CELL_WIDTH-1:0] sxwdata0,
   output logic                  sxgnt0,
   output logic                  sxrvalid0,
   output logic [CELL_WIDTH-1:0] sxrdata0,
   input  logic                  sxreq1,
   input  logic                  sxlast1,
   input  logic                  sxwen1,
   input  logic [BW_INDEX-1:0]   sxindex1,
   input  logic [BW_WEN-1:0]     sxwstrb1,
   input  logic [CELL_WIDTH-1:0] sxwdata1,
   output logic                  sxgnt1,
   output logic                  sxrvalid1,
   output logic [CELL_WIDTH-1:0] sxrdata1,
   output logic [BW_INDEX-1:0]   cell_index,
   output logic                  cell_enable,
   output logic                  cell_wenable,
   output logic [BW_WEN-1:0]     cell_wenable_byte,
   output logic [CELL_WIDTH-1:0] cell_wdata,
   output logic                  cell_renable,
   input  logic [CELL_WIDTH-1:0] cell_rdata
);

   localparam int HCNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);
   localparam logic [HCNT_W-1:0] HOLD_MAX  = HCNT_W'(MAX_HOLD);

   logic [1:0]                 req, last, wen, gnt;
   logic [1:0][BW_INDEX-1:0]   idx;
   logic [1:0][BW_WEN-1:0]     strb;
   logic [1:0][CELL_WIDTH-1:0] wdata;

   arb_state_e        state;
   logic              rr;
   logic [HCNT_W-1:0] hcnt;
   logic [1:0]        rvalid;
   logic              any, win, gid, gv;

   assign req   = {sxreq1, sxreq0};
   assign last  = {sxlast1, sxlast0};
   assign wen   = {sxwen1, sxwen0};
   assign idx   = {sxindex1, sxindex0};
   assign strb  = {sxwstrb1, sxwstrb0};
   assign wdata = {sxwdata1, sxwdata0};

   sensor_sdk_rr_pick2 u_pick (
      .req (req),
      .rr  (rr),
      .any (any),
      .win (win)
   );

   // In an OWN state only the owner can be granted; gid then names the owner.
   always_comb begin
      gnt = 2'b00;
      gid = 1'b0;
      case (state)
         IDLE: begin
            gid      = win;
            gnt[win] = any;
         end
         OWN0: begin
            gid    = 1'b0;
            gnt[0] = req[0];
         end
         OWN1: begin
            gid    = 1'b1;
            gnt[1] = req[1];
         end
         default: ;
      endcase
   end

   assign gv     = |gnt;
   assign sxgnt0 = gnt[0];
   assign sxgnt1 = gnt[1];

   assign cell_enable       = gv;
   assign cell_wenable      = gv & wen[gid];
   assign cell_renable      = gv & ~wen[gid];
   assign cell_wenable_byte = cell_wenable ? strb[gid] : '0;
   assign cell_index        = gv ? idx[gid] : '0;
   assign cell_wdata        = gv ? wdata[gid] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         rr     <= 1'b0;
         hcnt   <= '0;
         rvalid <= 2'b00;
      end else begin
         rvalid    <= 2'b00;
         rvalid[gid] <= cell_renable;
         case (state)
            IDLE: begin
               if (any) begin
                  // A one-beat hold limit releases right away while the other side waits.
                  if (last[win] || (MAX_HOLD == 1 && req[~win])) begin
                     rr <= ~win;
                  end else begin
                     state <= win ? OWN1 : OWN0;
                     hcnt  <= HCNT_W'(1);
                  end
               end
            end
            OWN0, OWN1: begin
               if (!req[gid] || last[gid] || (hcnt >= HOLD_LAST && req[~gid])) begin
                  state <= IDLE;
                  rr    <= ~gid;
                  hcnt  <= '0;
               end else if (hcnt != HOLD_MAX) begin
                  hcnt <= hcnt + HCNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               hcnt  <= '0;
            end
         endcase
      end
   end

   assign sxrvalid0 = rvalid[0];
   assign sxrvalid1 = rvalid[1];
   assign sxrdata0  = rvalid[0] ? cell_rdata : '0;
   assign sxrdata1  = rvalid[1] ? cell_rdata : '0;

endmodule

// File: tb/tb_sensor_sdk_sram_cell_arbiter.sv
// Directed bench: a cell model answers reads, a shadow memory predicts read data,
// and a scoreboard matches each granted read against the rvalid one cycle later.
module tb_sensor_sdk_sram_cell_arbiter;

   logic clk, rst;
   logic [1:0]        r_req, r_last, r_wen;
   logic [1:0][14:0]  r_idx;
   logic [1:0][3:0]   r_strb;
   logic [1:0][31:0]  r_data;

   logic        sxgnt0, sxgnt1, sxrvalid0, sxrvalid1;
   logic [31:0] sxrdata0, sxrdata1;
   logic [14:0] cell_index;
   logic        cell_enable, cell_wenable, cell_renable;
   logic [3:0]  cell_wenable_byte;
   logic [31:0] cell_wdata, cell_rdata;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   bit [31:0] mem [0:255];
   bit [31:0] sh  [0:255];

   typedef struct {
      bit        id;
      bit [31:0] data;
      int        cyc;
   } exp_t;
   exp_t sb[$];

   sensor_sdk_sram_cell_arbiter #(.BW_INDEX(15), .CELL_WIDTH(32), .MAX_HOLD(16)) dut (
      .clk(clk), .rst(rst),
      .sxreq0(r_req[0]), .sxlast0(r_last[0]), .sxwen0(r_wen[0]), .sxindex0(r_idx[0]),
      .sxwstrb0(r_strb[0]), .sxwdata0(r_data[0]), .sxgnt0(sxgnt0), .sxrvalid0(sxrvalid0),
      .sxrdata0(sxrdata0),
      .sxreq1(r_req[1]), .sxlast1(r_last[1]), .sxwen1(r_wen[1]), .sxindex1(r_idx[1]),
      .sxwstrb1(r_strb[1]), .sxwdata1(r_data[1]), .sxgnt1(sxgnt1), .sxrvalid1(sxrvalid1),
      .sxrdata1(sxrdata1),
      .cell_index(cell_index), .cell_enable(cell_enable), .cell_wenable(cell_wenable),
      .cell_wenable_byte(cell_wenable_byte), .cell_wdata(cell_wdata),
      .cell_renable(cell_renable), .cell_rdata(cell_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Cell model: byte-masked write, synchronous read.
   always @(posedge clk) begin
      if (cell_enable) begin
         if (cell_wenable)
            for (int b = 0; b < 4; b++)
               if (cell_wenable_byte[b]) mem[cell_index[7:0]][8*b +: 8] = cell_wdata[8*b +: 8];
         if (cell_renable) cell_rdata <= mem[cell_index[7:0]];
      end
   end

   // Response monitor: a read granted last cycle must return now, on its own port only.
   always @(negedge clk) begin
      exp_t e;
      logic [1:0]  rv;
      logic [31:0] got, oth;
      rv = {sxrvalid1, sxrvalid0};
      if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
         e   = sb.pop_front();
         got = e.id ? sxrdata1 : sxrdata0;
         oth = e.id ? sxrdata0 : sxrdata1;
         checks++;
         assert (rv === (e.id ? 2'b10 : 2'b01)) else begin
            failures++; $error("FAIL rvalid got=%b exp=%b", rv, (e.id ? 2'b10 : 2'b01));
         end
         checks++;
         assert (got === e.data) else begin
            failures++; $error("FAIL rdata%0d got=%h exp=%h", e.id, got, e.data);
         end
         checks++;
         assert (oth === 32'h0) else begin
            failures++; $error("FAIL rdata_other got=%h exp=0", oth);
         end
      end else begin
         checks++;
         assert (rv === 2'b00) else begin
            failures++; $error("FAIL rvalid_idle got=%b exp=00", rv);
         end
      end
   end

   task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
      checks++;
      assert (got === exp) else begin
         failures++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set(input int p, input logic req, input logic wen, input logic lst,
                      input logic [14:0] idx, input logic [3:0] strb, input logic [31:0] data);
      r_req[p]  = req;
      r_wen[p]  = wen;
      r_last[p] = lst;
      r_idx[p]  = idx;
      r_strb[p] = strb;
      r_data[p] = data;
   endtask

   // Check grants mid-cycle, record the predicted effect of each expected grant,
   // then move to just after the next rising edge.
   task automatic cyc_chk(input logic e0, input logic e1, input string tag);
      logic [1:0] eg;
      eg = {e1, e0};
      #3;
      chk({31'b0, sxgnt0}, {31'b0, e0}, {tag, "_gnt0"});
      chk({31'b0, sxgnt1}, {31'b0, e1}, {tag, "_gnt1"});
      for (int p = 0; p < 2; p++) begin
         if (eg[p]) begin
            if (!r_wen[p])
               sb.push_back('{id: p[0], data: sh[r_idx[p][7:0]], cyc: cyc});
            else
               for (int b = 0; b < 4; b++)
                  if (r_strb[p][b]) sh[r_idx[p][7:0]][8*b +: 8] = r_data[p][8*b +: 8];
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      r_req = 2'b00;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      r_req = '0; r_last = '0; r_wen = '0; r_idx = '0; r_strb = '0; r_data = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = {4{i[7:0]}};
         sh[i]  = {4{i[7:0]}};
      end
      mem[16] = 32'hDEADBEEF;
      sh[16]  = 32'hDEADBEEF;

      repeat (2) @(posedge clk);
      #1;
      chk({31'b0, sxrvalid0}, 32'h0, "rst_rvalid0");
      chk({31'b0, sxrvalid1}, 32'h0, "rst_rvalid1");
      chk({31'b0, cell_enable}, 32'h0, "rst_cell_enable");
      rst = 1'b0;
      @(posedge clk); #1;

      // single read from requester 0
      set(0, 1, 0, 1, 15'h10, 4'h0, 32'h0);
      #2;
      chk({31'b0, cell_renable}, 32'h1, "rd_renable");
      chk({17'b0, cell_index}, 32'h10, "rd_index");
      cyc_chk(1, 0, "single_read");
      r_req[0] = 1'b0;

      // strobed write from requester 1
      set(1, 1, 1, 1, 15'h3, 4'b0101, 32'h11223344);
      #2;
      chk({31'b0, cell_wenable}, 32'h1, "wr_wenable");
      chk({28'b0, cell_wenable_byte}, 32'h5, "wr_byte");
      chk(cell_wdata, 32'h11223344, "wr_wdata");
      chk({31'b0, cell_renable}, 32'h0, "wr_renable");
      cyc_chk(0, 1, "write");
      r_req[1] = 1'b0;

      // read back the merged word
      set(0, 1, 0, 1, 15'h3, 4'h0, 32'h0);
      cyc_chk(1, 0, "readback");
      r_req[0] = 1'b0;
      @(posedge clk); #1;

      // contention right after reset alternates with no bubble
      do_reset();
      set(0, 1, 0, 1, 15'h40, 4'h0, 32'h0);
      set(1, 1, 0, 1, 15'h41, 4'h0, 32'h0);
      cyc_chk(1, 0, "contend0");
      cyc_chk(0, 1, "contend1");
      cyc_chk(1, 0, "contend2");
      cyc_chk(0, 1, "contend3");
      r_req = 2'b00;

      // 8-beat burst holds the cell, then the waiter goes next
      set(1, 1, 0, 1, 15'h50, 4'h0, 32'h0);
      for (int b = 0; b < 8; b++) begin
         set(0, 1, 0, (b == 7), 15'(8'h60 + b), 4'h0, 32'h0);
         cyc_chk(1, 0, "burst_hold");
      end
      r_req[0] = 1'b0;
      cyc_chk(0, 1, "burst_next");
      r_req[1] = 1'b0;

      // 40-beat burst is forced off after 16 beats, then resumes
      set(1, 1, 0, 1, 15'h70, 4'h0, 32'h0);
      for (int b = 0; b < 40; b++) begin
         set(0, 1, 0, (b == 39), 15'(8'h80 + b), 4'h0, 32'h0);
         if (b == 16) begin
            cyc_chk(0, 1, "forced_handover");
            r_req[1] = 1'b0;
         end
         cyc_chk(1, 0, "forced_burst");
      end
      r_req[0] = 1'b0;

      // owner dropping its request costs a one-cycle bubble
      set(0, 1, 0, 0, 15'h90, 4'h0, 32'h0);
      cyc_chk(1, 0, "bubble_own");
      r_idx[0] = 15'h91;
      cyc_chk(1, 0, "bubble_own");
      r_req[0] = 1'b0;
      set(1, 1, 0, 1, 15'h92, 4'h0, 32'h0);
      cyc_chk(0, 0, "bubble");
      cyc_chk(0, 1, "bubble_after");
      r_req[1] = 1'b0;

      // reset right after a read grant inside a burst drops the response
      set(0, 1, 0, 0, 15'hA0, 4'h0, 32'h0);
      cyc_chk(1, 0, "rstmid_b0");
      r_idx[0] = 15'hA1;
      cyc_chk(1, 0, "rstmid_b1");
      rst = 1'b1;
      r_req = 2'b00;
      sb.delete();
      #2;
      chk({31'b0, sxrvalid0}, 32'h0, "rstmid_rvalid0");
      @(posedge clk); #1;
      rst = 1'b0;
      set(0, 1, 0, 1, 15'hB0, 4'h0, 32'h0);
      set(1, 1, 0, 1, 15'hB1, 4'h0, 32'h0);
      cyc_chk(1, 0, "post_rst0");
      cyc_chk(0, 1, "post_rst1");
      r_req = 2'b00;

      repeat (3) @(posedge clk);
      #1;
      chk(32'(sb.size()), 32'h0, "sb_drained");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
